// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : APB4 completer holding a DEPTH-word memory. Supports wait
//               states, byte strobes, and slave errors for bad accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int WP_WORDS    = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [MEM_AW-1:0]     widx_q, widx_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic [31:0]       idx;
  logic [MEM_AW-1:0] rd_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              protected_wr;
  logic              addr_err;

  assign idx          = 32'(paddr >> OFF_W);
  assign rd_idx       = idx[MEM_AW-1:0];
  assign misaligned   = |(paddr & OFF_MASK);
  assign out_of_range = idx >= 32'(DEPTH);
  // Written as idx+1 <= WP_WORDS so WP_WORDS=0 needs no special case
  assign protected_wr = pwrite && ((idx + 32'd1) <= 32'(WP_WORDS));
  assign addr_err     = misaligned || out_of_range || protected_wr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_d     = wr_q;
    widx_d   = widx_q;
    prdata_d = prdata_q;
    mem_d    = mem_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d  = ACCESS;
          cnt_d    = WAIT_INIT;
          err_d    = addr_err;
          wr_d     = pwrite;
          widx_d   = rd_idx;
          prdata_d = (!pwrite && !addr_err) ? mem_q[rd_idx] : '0;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (penable) begin
          state_d = IDLE;
          if (wr_q && !err_q) begin
            for (int i = 0; i < STRB_W; i++) begin
              if (pstrb[i]) mem_d[widx_q][8*i +: 8] = pwdata[8*i +: 8];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      widx_q   <= '0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      widx_q   <= widx_d;
      prdata_q <= prdata_d;
      mem_q    <= mem_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign pslverr = pready && err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_mem
// Description : Scoreboard bench for apb_slave_mem, 2-wait and 0-wait builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_mem;

  localparam int AW    = 9;
  localparam int DEPTH = 64;
  localparam int WP    = 4;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        presetn [2];
  logic [AW-1:0] paddr [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  logic [31:0] model_mem [2][DEPTH];
  exp_t        exp_q0 [$];
  exp_t        exp_q1 [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(2), .WP_WORDS(WP)) u_dut_ws2 (
    .pclk(clk), .presetn(presetn[0]), .paddr(paddr[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]));

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0), .WP_WORDS(WP)) u_dut_ws0 (
    .pclk(clk), .presetn(presetn[1]), .paddr(paddr[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit model_err(input bit wr, input logic [AW-1:0] a);
    int w;
    w = int'(a) / 4;
    return (int'(a) % 4 != 0) || (w >= DEPTH) || (wr && w < WP);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_pop(input int d);
    exp_t e;
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_completion: dut %0d completed with nothing outstanding", d);
      return;
    end
    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check({e.name, "_pslverr"}, {31'b0, pslverr[d]}, {31'b0, e.err});
    if (e.rd) check({e.name, "_prdata"}, prdata[d], e.data);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (presetn[d] && psel[d] && penable[d] && pready[d]) mon_pop(d);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the completing edge
  task automatic apb_xfer(input int d, input bit wr, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          input string nm, input bit use_c, input logic [31:0] cval);
    exp_t e;
    int   w;
    int   n;
    w      = int'(a) / 4;
    e.rd   = !wr;
    e.err  = model_err(wr, a);
    e.name = nm;
    e.data = 32'h0;
    if (!wr) begin
      if (!e.err) e.data = model_mem[d][w];
      if (use_c) e.data = cval;
    end else if (!e.err) begin
      for (int i = 0; i < 4; i++) if (st[i]) model_mem[d][w][8*i +: 8] = wd[8*i +: 8];
    end
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    paddr[d] = a; pwrite[d] = wr; pwdata[d] = wd; pstrb[d] = st;
    psel[d] = 1'b1; penable[d] = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready[d]) break;
      n++;
      if (n > 40) break;
    end
    check({nm, "_latency"}, 32'(n), 32'(ws_of(d)));
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_outputs_zero(input int d, input string nm);
    check({nm, "_pready"},  {31'b0, pready[d]},  32'h0);
    check({nm, "_pslverr"}, {31'b0, pslverr[d]}, 32'h0);
    check({nm, "_prdata"},  prdata[d],           32'h0);
  endtask

  task automatic rand_xfers(input int d, input int count);
    logic [AW-1:0] a;
    bit            wr;
    for (int k = 0; k < count; k++) begin
      if ($urandom_range(0, 4) != 0) a = AW'($urandom_range(0, DEPTH - 1) * 4);
      else                           a = AW'($urandom_range(0, (1 << AW) - 1));
      wr = bit'($urandom_range(0, 1));
      apb_xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), "rand", 1'b0, 32'h0);
      idle($urandom_range(0, 1));
    end
  endtask

  initial begin
    int start;
    for (int d = 0; d < 2; d++) begin
      presetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[d][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    presetn[0] = 1'b1; presetn[1] = 1'b1;
    @(negedge clk);
    check_outputs_zero(0, "reset_ws2");
    check_outputs_zero(1, "reset_ws0");
    @(posedge clk); #1;

    apb_xfer(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, "t1_wr", 1'b0, 32'h0);
    apb_xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, "t1_rd", 1'b1, 32'hDEADBEEF);

    apb_xfer(0, 1'b1, 9'h020, 32'h11223344, 4'hF, "t2_wr_full", 1'b0, 32'h0);
    apb_xfer(0, 1'b1, 9'h020, 32'hAABBCCDD, 4'h5, "t2_wr_strb", 1'b0, 32'h0);
    apb_xfer(0, 1'b0, 9'h020, 32'h0, 4'h0, "t2_rd", 1'b1, 32'h11BB33DD);
    apb_xfer(0, 1'b1, 9'h020, 32'hFFFFFFFF, 4'h0, "t2_wr_nostrb", 1'b0, 32'h0);
    apb_xfer(0, 1'b0, 9'h020, 32'h0, 4'h0, "t2_rd_nostrb", 1'b1, 32'h11BB33DD);

    apb_xfer(0, 1'b1, 9'h004, 32'h12345678, 4'hF, "t3_wr_prot", 1'b0, 32'h0);
    apb_xfer(0, 1'b0, 9'h004, 32'h0, 4'h0, "t3_rd_prot", 1'b1, 32'h0);
    apb_xfer(0, 1'b0, 9'h002, 32'h0, 4'h0, "t3_rd_misal", 1'b1, 32'h0);
    apb_xfer(0, 1'b0, 9'h100, 32'h0, 4'h0, "t3_rd_range", 1'b1, 32'h0);

    start = cyc;
    for (int i = 0; i < 8; i++) apb_xfer(0, 1'b1, AW'(9'h040 + 4 * i), $urandom, 4'hF, "t4_wr", 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) apb_xfer(0, 1'b0, AW'(9'h040 + 4 * i), 32'h0, 4'h0, "t4_rd", 1'b0, 32'h0);
    check("t4_b2b_cycles", 32'(cyc - start), 32'd64);

    apb_xfer(0, 1'b1, 9'h030, 32'h0BADF00D, 4'hF, "t5_wr_prior", 1'b0, 32'h0);
    paddr[0] = 9'h030; pwrite[0] = 1'b1; pwdata[0] = 32'h55; pstrb[0] = 4'hF;
    psel[0] = 1'b1; penable[0] = 1'b0;
    @(posedge clk); #1; penable[0] = 1'b1;
    @(posedge clk); #1; psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_abort_pready", {31'b0, pready[0]}, 32'h0);
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 9'h030, 32'h0, 4'h0, "t5_rd_after_abort", 1'b1, 32'h0BADF00D);

    paddr[0] = 9'h030; pwrite[0] = 1'b1; pwdata[0] = 32'h77777777; pstrb[0] = 4'hF;
    psel[0] = 1'b1; penable[0] = 1'b0;
    @(posedge clk); #1; penable[0] = 1'b1;
    @(posedge clk); #1; presetn[0] = 1'b0;
    @(posedge clk); #1; presetn[0] = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[0][i] = 32'h0;
    @(negedge clk);
    check_outputs_zero(0, "t5_midreset");
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 9'h030, 32'h0, 4'h0, "t5_rd_cleared", 1'b1, 32'h0);
    apb_xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, "t5_rd_other_cleared", 1'b1, 32'h0);

    rand_xfers(0, 60);

    start = cyc;
    apb_xfer(1, 1'b1, 9'h03C, 32'hCAFEF00D, 4'hF, "t6_wr", 1'b0, 32'h0);
    apb_xfer(1, 1'b0, 9'h03C, 32'h0, 4'h0, "t6_rd", 1'b1, 32'hCAFEF00D);
    check("t6_cycles", 32'(cyc - start), 32'd4);
    rand_xfers(1, 30);

    idle(3);
    check("leftover_ws2", 32'(exp_q0.size()), 32'd0);
    check("leftover_ws0", 32'(exp_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/apb_slave_mem.md
# apb_slave_mem

Parametrised APB4 completer that holds a `DEPTH`-word register memory, generalising the fixed-width, zero-wait APB slave in the APB verification environment. Adds:
- programmable wait states via `pready`
- byte-lane write strobes
- error response via `pslverr` for misaligned, out-of-range and write-protected accesses

Sits behind an APB bridge or the testbench APB master interface as a drop-in memory-mapped target.

## Interface
- `ADDR_WIDTH`, 8: `paddr` width; byte address.
- `DATA_WIDTH`, 32: data width; one of 8/16/32/64.
- `DEPTH`, 64: number of words; at most 2^(`ADDR_WIDTH` - log2(`DATA_WIDTH`/8)).
- `WAIT_STATES`, 0: `pready`-low cycles per access, 0..15.
- `WP_WORDS`, 0: words 0..`WP_WORDS`-1 are write-protected; 0 means none.

Ports:
- `pclk` input 1: clock; all logic on rising edge.
- `presetn` input 1: reset; synchronous, active-low.
- `paddr` input `ADDR_WIDTH`: byte address.
- `psel` input 1: select.
- `penable` input 1: access phase.
- `pwrite` input 1: 1 = write, 0 = read.
- `pwdata` input `DATA_WIDTH`: write data.
- `pstrb` input `DATA_WIDTH`/8: byte-lane write enables.
- `prdata` output `DATA_WIDTH`: read data.
- `pready` output 1: transfer completes this cycle.
- `pslverr` output 1: error; valid only while `pready`=1.

## Operation
- **Reset** (`presetn`=0 at a rising edge):
  - FSM goes to IDLE, wait counter = 0, error flag = 0.
  - `prdata` = 0, `pready` = 0, `pslverr` = 0.
  - All memory words cleared to 0.
- **Address decode:**
  - Word index = `paddr` >> log2(`DATA_WIDTH`/8).
  - Error if the low byte-offset bits are nonzero (misaligned).
  - Error if index ≥ `DEPTH`.
  - Error if `pwrite`=1 and index < `WP_WORDS`.
- **FSM states:** IDLE, ACCESS.
- **IDLE:**
  - On an edge with `psel`=1 and `penable`=0 (setup phase), go to ACCESS.
  - Latch the error flag and set counter = `WAIT_STATES`.
  - Latch `prdata` = mem[index] for a non-error read; otherwise `prdata` = 0.
  - Any other input combination leaves the FSM in IDLE.
- **ACCESS:**
  - `pready` = (counter == 0), combinational from state and counter.
  - While counter ≠ 0 and `psel`=1, decrement the counter each edge.
  - When counter = 0 with `psel` = `penable` = 1, the transfer completes at that edge and the FSM returns to IDLE.
  - A completing write without error updates byte lane *i* with `pwdata` lane *i* only where `pstrb`[*i*]=1.
  - `pstrb` = 0 on a write: no update, no error.
- **Error:** `pslverr` = `pready` AND latched error flag. An erroring write never modifies memory. An erroring read returns `prdata` = 0.
- **Abort:** if `psel`=0 at any edge in ACCESS, return to IDLE with no memory update. `pready` and `pslverr` fall with the state.
- **Hold:** `prdata` holds its last value in IDLE until the next setup phase.
- **Read-during-write:** impossible, since only one transfer is in flight. A read issued immediately after a write returns the new data.

## Timing
- **Minimum transfer:** 2 cycles (setup + access) with `WAIT_STATES`=0. In general the transfer takes 2 + `WAIT_STATES` cycles.
- **Back-to-back transfers:** a new setup phase is accepted on the cycle immediately after completion. Sustained throughput is one transfer per 2 + `WAIT_STATES` cycles.
- **Read data:** `prdata` is valid from the first access cycle, i.e. one cycle after the setup edge. It is stable through all wait states.
- **Write commit:** memory updates at the completing edge and is visible to a read whose setup phase occurs on the next cycle.
- **Reset mid-transfer:** an in-flight write is dropped. Outputs reach their reset values at the reset edge.
- **Unchanged inputs:** `paddr`, `pwrite`, `pwdata` and `pstrb` are sampled at setup and held stable by the master per APB. At completion the block uses `pwdata`/`pstrb` as sampled on the completing edge.

## Test plan
Configuration for all scenarios: `DATA_WIDTH`=32, `DEPTH`=64, `WAIT_STATES`=2, `WP_WORDS`=4.

1. **Reset and basic write/read:** reset, write 0xDEADBEEF to 0x10 with `pstrb`=0xF, read 0x10 → `pready` high on the 3rd access cycle, `prdata`=0xDEADBEEF, `pslverr`=0. Each transfer takes 4 cycles.
2. **Byte strobes:** write 0x11223344 to 0x20 (`pstrb`=0xF), then write 0xAABBCCDD with `pstrb`=0x5, read 0x20 → 0x11BB33DD.
3. **Errors:**
   - write to 0x04 (protected) → `pslverr`=1, later read 0x04 returns 0.
   - read 0x02 (misaligned) → `pslverr`=1, `prdata`=0.
   - read 0x100 with `ADDR_WIDTH`=9 (index 64) → `pslverr`=1.
4. **Back-to-back:** 8 consecutive writes to 0x40..0x5C followed immediately by 8 reads → all data match; no idle cycles beyond the setup phases; total 64 cycles.
5. **Abort and reset:**
   - Drop `psel` in the 2nd access cycle of a write of 0x55 to 0x30 → word stays at its prior value, FSM back in IDLE.
   - Assert `presetn`=0 during the wait states of a write → memory word = 0, `pready`/`pslverr`/`prdata` = 0.
6. **Zero-wait variant:** with `WAIT_STATES`=0, `pready`=1 in the first access cycle; write then read of 0xCAFEF00D at 0x3C returns it with 2-cycle transfers.
